// File: rtl/alu_sequencer.sv
// alu_sequencer: accepts one ALU request at a time, registers the datapath operands, waits a settle interval, then captures and holds the result.
// Ports:
//   clk, resetN                        clock, async active-low reset
//   start, xIn, yIn, opIn              request and operands, sampled in IDLE
//   x, y, ynot, z, operation           registered operand forms to the datapath
//   returnValue, addSuboverflow        datapath result and add/sub carry
//   busy                               high outside IDLE
//   result, overflow, divByZero        captured result and flags
//   resultValid, resultAck             result handshake
//   opCount                            completed-operation counter
module alu_sequencer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       start,
  input  logic [3:0] xIn,
  input  logic [3:0] yIn,
  input  logic [1:0] opIn,
  output logic [3:0] x,
  output logic [3:0] y,
  output logic [3:0] ynot,
  output logic [7:0] z,
  output logic [1:0] operation,
  input  logic [7:0] returnValue,
  input  logic       addSuboverflow,
  output logic       busy,
  output logic [7:0] result,
  output logic       overflow,
  output logic       divByZero,
  output logic       resultValid,
  input  logic       resultAck,
  output logic [7:0] opCount
);
  typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;
  state_t state;
  logic [3:0] cnt;
  logic div_zero;
  assign div_zero = operation == 2'd3 && y == 4'd0;
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      state <= IDLE;
      cnt <= '0;
      x <= '0;
      y <= '0;
      ynot <= '0;
      z <= '0;
      operation <= '0;
      busy <= 1'b0;
      result <= '0;
      overflow <= 1'b0;
      divByZero <= 1'b0;
      resultValid <= 1'b0;
      opCount <= '0;
    end else
      case (state)
        IDLE:
          if (start) begin
            x <= xIn;
            y <= yIn;
            ynot <= ~yIn + 4'd1;
            z <= {xIn, yIn};
            operation <= opIn;
            cnt <= 4'(SETTLE_CYCLES - 1);
            busy <= 1'b1;
            state <= SETTLE;
          end
        SETTLE:
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
          else begin
            result <= div_zero ? 8'h00 : returnValue;
            // carry is only meaningful for add/sub (op[1] clear)
            overflow <= ~operation[1] & addSuboverflow;
            divByZero <= div_zero;
            resultValid <= 1'b1;
            opCount <= opCount + 8'd1;
            state <= DONE;
          end
        DONE:
          if (resultAck) begin
            resultValid <= 1'b0;
            busy <= 1'b0;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: randomized self-checking bench for alu_sequencer against a transaction-level model.
module tb_alu_sequencer;
  localparam int S = 2;
  logic clk = 1'b0;
  logic resetN, start, resultAck;
  logic [3:0] xIn, yIn;
  logic [1:0] opIn;
  logic [3:0] x, y, ynot;
  logic [7:0] z, returnValue, result, opCount;
  logic [1:0] operation;
  logic addSuboverflow, busy, overflow, divByZero, resultValid;
  logic [4:0] sum;
  int errs = 0;
  int checks = 0;
  int cnt_model = 0;
  alu_sequencer #(.SETTLE_CYCLES(S)) dut (
    .clk(clk), .resetN(resetN), .start(start), .xIn(xIn), .yIn(yIn), .opIn(opIn),
    .x(x), .y(y), .ynot(ynot), .z(z), .operation(operation),
    .returnValue(returnValue), .addSuboverflow(addSuboverflow), .busy(busy),
    .result(result), .overflow(overflow), .divByZero(divByZero),
    .resultValid(resultValid), .resultAck(resultAck), .opCount(opCount)
  );
  always #5 clk = ~clk;
  // datapath stand-in: add/sub via ynot, raw product, quotient with 8'hFF on y=0, carry forced high for mul/div
  always_comb begin
    sum = 5'(x) + 5'(operation == 2'd1 ? ynot : y);
    returnValue = operation[1] ? (operation[0] ? (y == 4'd0 ? 8'hFF : 8'(x / y)) : 8'(x * y)) : {4'h0, sum[3:0]};
    addSuboverflow = operation[1] ? 1'b1 : sum[4];
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check_zero(input string tag);
    chk({tag, "_x"}, x, 0);
    chk({tag, "_y"}, y, 0);
    chk({tag, "_ynot"}, ynot, 0);
    chk({tag, "_z"}, z, 0);
    chk({tag, "_op"}, operation, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_ovf"}, overflow, 0);
    chk({tag, "_dbz"}, divByZero, 0);
    chk({tag, "_valid"}, resultValid, 0);
    chk({tag, "_count"}, opCount, 0);
  endtask
  task automatic run_op(input int xi, input int yi, input int op, input int hold, input bit noise);
    int yn, s, er, eo, ed;
    yn = (16 - yi) % 16;
    s = xi + (op == 1 ? yn : yi);
    er = op == 0 || op == 1 ? s % 16 : op == 2 ? xi * yi : yi == 0 ? 0 : xi / yi;
    eo = op < 2 && s > 15;
    ed = op == 3 && yi == 0;
    start = 1'b1;
    xIn = 4'(xi);
    yIn = 4'(yi);
    opIn = 2'(op);
    resultAck = 1'b0;
    tick();
    start = 1'b0;
    if (noise) begin
      xIn = 4'($urandom);
      yIn = 4'($urandom);
      opIn = 2'($urandom);
    end
    chk("x", x, xi);
    chk("y", y, yi);
    chk("ynot", ynot, yn);
    chk("z", z, xi * 16 + yi);
    chk("operation", operation, op);
    chk("busy_accept", busy, 1);
    chk("valid_accept", resultValid, 0);
    for (int i = 1; i <= S; i++) begin
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      resultAck = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      if (i < S) chk("valid_early", resultValid, 0);
    end
    start = 1'b0;
    resultAck = 1'b0;
    cnt_model = (cnt_model + 1) % 256;
    chk("valid_capture", resultValid, 1);
    chk("result", result, er);
    chk("overflow", overflow, eo);
    chk("divByZero", divByZero, ed);
    chk("opCount", opCount, cnt_model);
    chk("busy_done", busy, 1);
    repeat (hold) begin
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      xIn = 4'($urandom);
      tick();
      chk("hold_valid", resultValid, 1);
      chk("hold_result", result, er);
      chk("hold_x", x, xi);
      chk("hold_count", opCount, cnt_model);
    end
    start = noise ? 1'b1 : 1'b0;
    resultAck = 1'b1;
    tick();
    start = 1'b0;
    resultAck = 1'b0;
    chk("ack_valid", resultValid, 0);
    chk("ack_busy", busy, 0);
    chk("ack_x", x, xi);
    chk("ack_result", result, er);
  endtask
  initial begin
    resetN = 1'b0;
    start = 1'b0;
    resultAck = 1'b0;
    xIn = '0;
    yIn = '0;
    opIn = '0;
    #1;
    check_zero("reset");
    tick();
    resetN = 1'b1;
    tick();
    start = 1'b1;
    xIn = 4'h6;
    yIn = 4'h2;
    opIn = 2'd2;
    tick();
    start = 1'b0;
    chk("mid_busy", busy, 1);
    #2 resetN = 1'b0;
    #1;
    check_zero("mid_reset");
    tick();
    tick();
    resetN = 1'b1;
    run_op(4'h9, 4'h8, 0, 0, 1'b0);
    run_op(5, 3, 1, 1, 1'b0);
    run_op(4'hF, 4'hF, 2, 0, 1'b0);
    run_op(7, 0, 3, 2, 1'b0);
    run_op(9, 4, 1, 10, 1'b1);
    for (int i = 0; i < 40; i++)
      run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
    start = 1'b1;
    resultAck = 1'b1;
    for (int h = 1; h <= 2; h++) begin
      repeat (128 * (S + 2)) begin
        xIn = 4'($urandom);
        yIn = 4'($urandom);
        opIn = 2'($urandom);
        tick();
      end
      chk("burst_count", opCount, (cnt_model + 128 * h) % 256);
      chk("burst_busy", busy, 0);
    end
    start = 1'b0;
    resultAck = 1'b0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Sequencing controller for the 4-bit arithmetic datapath (add/subtract/multiply/divide with an 8-bit result and an add/sub overflow bit). It accepts one operation request at a time from the top level, registers the operands and the operation select, and derives the operand forms the datapath consumes: `y`, two's-complement `ynot`, and packed `z`. It waits a fixed settle interval, then captures the datapath result and flags. The captured result is held with a valid/acknowledge handshake for the display/top logic. It also counts completed operations.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 2: cycles the registered operands are held before the datapath output is captured. Legal range 1–15.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `resetN` input 1: asynchronous, active-low reset.
- `start` input 1: request; sampled only in IDLE.
- `xIn` input 4: operand x from switches.
- `yIn` input 4: operand y from switches.
- `opIn` input 2: operation select. 0 = add, 1 = subtract, 2 = multiply, 3 = divide.
- `x` output 4: registered x to the datapath.
- `y` output 4: registered y to the datapath.
- `ynot` output 4: registered (~y + 1) mod 16 to the datapath.
- `z` output 8: registered {x, y} to the datapath.
- `operation` output 2: registered op select to the datapath.
- `returnValue` input 8: datapath result.
- `addSuboverflow` input 1: datapath add/sub carry.
- `busy` output 1: high in any state other than IDLE.
- `result` output 8: captured result.
- `overflow` output 1: captured carry. Valid for op 0/1 only; forced 0 for op 2/3.
- `divByZero` output 1: captured flag for op 3 with y = 0.
- `resultValid` output 1: captured result available.
- `resultAck` input 1: consumer acknowledge.
- `opCount` output 8: completed-operation counter, wraps 255 → 0.

## Operation
- States: IDLE, SETTLE, DONE. Reset state is IDLE.
- Reset value of every output is 0: `x`, `y`, `ynot`, `z`, `operation`, `busy`, `result`, `overflow`, `divByZero`, `resultValid`, `opCount`.
- **IDLE:**
  - On `start` = 1, register `xIn`, `yIn`, `opIn` into `x`, `y`, `operation`.
  - In the same edge, register `ynot` = (~`yIn` + 1)[3:0] and `z` = {`xIn`, `yIn`}.
  - Load settle counter with SETTLE_CYCLES−1 and go to SETTLE.
  - Otherwise stay in IDLE.
- **SETTLE:**
  - If counter ≠ 0, decrement.
  - If counter = 0, capture and go to DONE. Capture means:
    - `result` = `returnValue`.
    - `overflow` = `addSuboverflow` when `operation` ∈ {0,1}, else 0.
    - `divByZero` = (`operation` = 3 and `y` = 0).
    - When `divByZero` is set, `result` is forced to 8'h00 regardless of `returnValue`.
    - `resultValid` ← 1 and `opCount` ← `opCount` + 1.
- **DONE:**
  - Hold all outputs.
  - On `resultAck` = 1, clear `resultValid` and go to IDLE.
- Datapath-facing registers (`x`, `y`, `ynot`, `z`, `operation`) change only on an accepted start. They hold their values through DONE and IDLE until the next accept.
- `result`, `overflow` and `divByZero` hold their values until the next capture. `resultValid` is the only qualifier.
- `start` outside IDLE is ignored and not queued.
- `resultAck` outside DONE is ignored.
- `opIn`, `xIn` and `yIn` changes outside the accept edge have no effect.

## Timing
- Accept edge = the edge at which `start` is sampled high in IDLE. Call it edge k.
- `busy` rises after edge k. Datapath operands are stable from edge k.
- Capture occurs at edge k+SETTLE_CYCLES. `resultValid` is high from that edge.
- For SETTLE_CYCLES = 2: `start` at edge 0 → `resultValid` after edge 2.
- Ack at edge m in DONE: `resultValid` and `busy` fall after m, and the state is IDLE.
  - A new `start` is accepted no earlier than edge m+1.
  - `start` and `resultAck` both high at edge m gives the same result: only the ack takes effect.
- `start` held high continuously produces back-to-back operations. The period is SETTLE_CYCLES + 2 cycles when `resultAck` is tied high.
- `resetN` low at any time, including in SETTLE or DONE:
  - Immediately forces IDLE and all outputs to 0.
  - The in-flight operation is discarded and not counted.
  - After release, the first edge with `start` high is an accept.

## Test plan
- Reset, then add x=4'h9, y=4'h8, SETTLE_CYCLES=2, datapath model returning sum → `z`=8'h98, `ynot`=4'h8. After edge 2: `result`=8'h01, `overflow`=1, `resultValid`=1, `opCount`=1.
- Subtract x=5, y=3 → `ynot`=4'hD and `result`=8'h02 from the model. `overflow` equals the model carry (1).
- Multiply x=4'hF, y=4'hF with `addSuboverflow` forced 1 by the model → `result`=8'hE1, `overflow`=0.
- Divide x=7, y=0 with the model returning 8'hFF → `result`=8'h00, `divByZero`=1.
- Pulse `start` during SETTLE and DONE, hold `resultAck`=0 for 10 cycles:
  - `resultValid` stays 1 and `result` is unchanged.
  - The extra starts are not accepted.
  - `start`+`resultAck` together in DONE → IDLE only; accept occurs on the next edge.
- Assert `resetN`=0 mid-SETTLE → all outputs 0 asynchronously and `opCount` unchanged (0). Also run 256 ops with `resultAck` tied high → `opCount` wraps to 0.
